// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and the IF/ID payload type.
package mips_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Contents of one IF/ID pipeline register slot.
  typedef struct packed {
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
    logic            valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{pc4: '0, instr: NOP_INSTR, valid: 1'b0};

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction memory port, IF/ID outputs.
//   master : the fetch stage (drives imem_addr_o, ifid_*, oob_err_o, fetch_cnt_o)
//   slave  : the surrounding pipeline / memory model
interface if_fetch_stage_if #(
  parameter int unsigned CNT_W = 16
);
  logic             stall_i;
  logic             flush_i;
  logic             redirect_i;
  logic [31:0]      redirect_pc_i;
  logic [31:0]      imem_addr_o;
  logic [31:0]      imem_instr_i;
  logic [31:0]      ifid_pc4_o;
  logic [31:0]      ifid_instr_o;
  logic             ifid_valid_o;
  logic             oob_err_o;
  logic [CNT_W-1:0] fetch_cnt_o;

  modport master (
    input  stall_i, flush_i, redirect_i, redirect_pc_i, imem_instr_i,
    output imem_addr_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o, oob_err_o, fetch_cnt_o
  );

  modport slave (
    output stall_i, flush_i, redirect_i, redirect_pc_i, imem_instr_i,
    input  imem_addr_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o, oob_err_o, fetch_cnt_o
  );
endinterface

// File: rtl/if_id_reg.sv
// Pipeline register slot with bubble > hold > load priority.
//   clk_i, rst_i : clock, async active-high reset (resets to a bubble)
//   bubble_i     : replace contents with a bubble
//   hold_i       : keep current contents
//   load_i       : payload captured when neither bubble nor hold
//   q_o          : registered payload
module if_id_reg
  import mips_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  bubble_i,
  input  logic  hold_i,
  input  ifid_t load_i,
  output ifid_t q_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_o <= IFID_BUBBLE;
    end else if (bubble_i) begin
      q_o <= IFID_BUBBLE;
    end else if (!hold_i) begin
      q_o <= load_i;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS fetch stage: owns the PC, reads instruction memory combinationally and
// fills the IF/ID register; flags out-of-range fetches and counts valid loads.
//   clk_i, rst_i : clock, async active-high reset
//   bus          : if_fetch_stage_if.master (controls, imem port, IF/ID outputs)
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_WORDS = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  if_fetch_stage_if.master    bus
);

  // 33 bits so IMEM_WORDS*4 cannot overflow the comparison.
  localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_WORDS) * 33'(WORD_BYTES);

  logic [31:0]      pc_q;
  logic [31:0]      pc_d;
  logic [CNT_W-1:0] cnt_q;
  logic             oob_q;
  logic             in_range_c;
  logic             kill_c;
  logic             bubble_c;
  logic             load_valid_c;
  logic             oob_set_c;
  ifid_t            ifid_load_c;
  ifid_t            ifid_q;

  // Next PC and IF/ID control decode.
  always_comb begin
    in_range_c   = {1'b0, pc_q} < IMEM_LIMIT;
    kill_c       = bus.flush_i | bus.redirect_i;
    bubble_c     = kill_c | (~bus.stall_i & ~in_range_c);
    load_valid_c = ~kill_c & ~bus.stall_i & in_range_c;
    oob_set_c    = ~kill_c & ~bus.stall_i & ~in_range_c;
    ifid_load_c  = '{pc4: pc_q + 32'(WORD_BYTES), instr: bus.imem_instr_i, valid: 1'b1};
    pc_d         = pc_q + 32'(WORD_BYTES);
    if (bus.redirect_i) begin
      pc_d = {bus.redirect_pc_i[31:2], 2'b00};
    end else if (bus.stall_i) begin
      pc_d = pc_q;
    end
  end

  // PC, sticky out-of-range flag and saturating fetch counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q  <= RESET_PC;
      oob_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (oob_set_c) begin
        oob_q <= 1'b1;
      end
      if (load_valid_c && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  if_id_reg u_if_id_reg (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bubble_i (bubble_c),
    .hold_i   (bus.stall_i),
    .load_i   (ifid_load_c),
    .q_o      (ifid_q)
  );

  assign bus.imem_addr_o  = pc_q;
  assign bus.ifid_pc4_o   = ifid_q.pc4;
  assign bus.ifid_instr_o = ifid_q.instr;
  assign bus.ifid_valid_o = ifid_q.valid;
  assign bus.oob_err_o    = oob_q;
  assign bus.fetch_cnt_o  = cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios with literal expectations, then
// randomized control traffic checked every cycle against a behavioural model.
module tb_if_fetch_stage;

  localparam int unsigned IMEM_WORDS = 32;
  localparam int unsigned CNT_W      = 4;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam longint      LIMIT      = longint'(IMEM_WORDS) * 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_fetch_stage_if #(.CNT_W(CNT_W)) bus ();

  if_fetch_stage #(
    .RESET_PC   (RESET_PC),
    .IMEM_WORDS (IMEM_WORDS),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [31:0] mem [IMEM_WORDS];

  // Instruction memory: garbage outside the legal range so a stray load shows up.
  always_comb begin
    if (longint'(bus.imem_addr_o) < LIMIT)
      bus.imem_instr_i = mem[bus.imem_addr_o[6:2]];
    else
      bus.imem_instr_i = 32'hDEAD_BEEF;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: pipeline state as plain variables.
  logic [31:0]      m_pc, m_pc4, m_instr, cur;
  logic             m_valid, m_oob;
  int unsigned      m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = RESET_PC; m_pc4 = 0; m_instr = 0; m_valid = 0; m_oob = 0; m_cnt = 0;
    end else begin
      cur = m_pc;
      if (bus.flush_i || bus.redirect_i) begin
        m_pc4 = 0; m_instr = 0; m_valid = 0;
      end else if (bus.stall_i) begin
        // hold
      end else if (longint'(cur) < LIMIT) begin
        m_pc4 = cur + 4; m_instr = mem[cur >> 2]; m_valid = 1;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end else begin
        m_pc4 = 0; m_instr = 0; m_valid = 0; m_oob = 1;
      end
      if (bus.redirect_i)   m_pc = bus.redirect_pc_i & 32'hFFFF_FFFC;
      else if (!bus.stall_i) m_pc = cur + 4;
    end
  end

  logic cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("m_addr",  bus.imem_addr_o,  m_pc);
      chk("m_pc4",   bus.ifid_pc4_o,   m_pc4);
      chk("m_instr", bus.ifid_instr_o, m_instr);
      chk("m_valid", 32'(bus.ifid_valid_o), 32'(m_valid));
      chk("m_oob",   32'(bus.oob_err_o),    32'(m_oob));
      chk("m_cnt",   32'(bus.fetch_cnt_o),  m_cnt);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string name, input logic [31:0] pc4,
                          input logic [31:0] instr, input logic valid);
    chk({name, "_pc4"},   bus.ifid_pc4_o,   pc4);
    chk({name, "_instr"}, bus.ifid_instr_o, instr);
    chk({name, "_valid"}, 32'(bus.ifid_valid_o), 32'(valid));
  endtask

  initial begin
    bus.stall_i = 0; bus.flush_i = 0; bus.redirect_i = 0; bus.redirect_pc_i = 0;
    for (int i = 0; i < int'(IMEM_WORDS); i++) mem[i] = 32'h1000_0000 + 32'(i);

    // Reset state
    #12;
    chk("rst_addr", bus.imem_addr_o, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);
    chk("rst_oob", 32'(bus.oob_err_o), 32'h0);
    chk("rst_cnt", 32'(bus.fetch_cnt_o), 32'h0);
    rst = 0;
    cmp_en = 1;

    // Free run
    tick; chk("run_addr1", bus.imem_addr_o, 32'h4);  chk_ifid("run1", 32'h4, 32'h1000_0000, 1'b1);
    tick; chk("run_addr2", bus.imem_addr_o, 32'h8);  chk_ifid("run2", 32'h8, 32'h1000_0001, 1'b1);

    // Stall two cycles at pc 8
    bus.stall_i = 1;
    tick; tick;
    chk("stall_addr", bus.imem_addr_o, 32'h8);
    chk_ifid("stall", 32'h8, 32'h1000_0001, 1'b1);
    chk("stall_cnt", 32'(bus.fetch_cnt_o), 32'h2);
    bus.stall_i = 0;
    tick; chk("rel_addr", bus.imem_addr_o, 32'hC); chk_ifid("rel", 32'hC, 32'h1000_0002, 1'b1);
    chk("rel_cnt", 32'(bus.fetch_cnt_o), 32'h3);

    // Misaligned redirect at pc 12
    bus.redirect_i = 1; bus.redirect_pc_i = 32'h0000_0016;
    tick; chk("redir_addr", bus.imem_addr_o, 32'h14); chk_ifid("redir", 32'h0, 32'h0, 1'b0);
    bus.redirect_i = 0;
    tick; chk_ifid("redir_next", 32'h18, 32'h1000_0005, 1'b1);

    // Stall + flush at pc 0x10
    bus.redirect_i = 1; bus.redirect_pc_i = 32'h10;
    tick; bus.redirect_i = 0; bus.stall_i = 1; bus.flush_i = 1;
    tick; chk("sf_addr", bus.imem_addr_o, 32'h10); chk_ifid("sf", 32'h0, 32'h0, 1'b0);
    bus.stall_i = 0; bus.flush_i = 0;
    tick; chk_ifid("sf_next", 32'h14, 32'h1000_0004, 1'b1);
    chk("sf_cnt", 32'(bus.fetch_cnt_o), 32'h5);

    // Out-of-range fetch
    bus.redirect_i = 1; bus.redirect_pc_i = 32'h80;
    tick; bus.redirect_i = 0;
    tick; chk_ifid("oob", 32'h0, 32'h0, 1'b0);
    chk("oob_flag", 32'(bus.oob_err_o), 32'h1);
    chk("oob_cnt", 32'(bus.fetch_cnt_o), 32'h5);
    bus.redirect_i = 1; bus.redirect_pc_i = 32'h0;
    tick; bus.redirect_i = 0;
    tick; chk("oob_sticky", 32'(bus.oob_err_o), 32'h1);
    chk_ifid("oob_back", 32'h4, 32'h1000_0000, 1'b1);

    // Async reset between edges during a stall
    bus.stall_i = 1;
    tick; #2;
    rst = 1; #1;
    chk("arst_addr", bus.imem_addr_o, RESET_PC);
    chk_ifid("arst", 32'h0, 32'h0, 1'b0);
    chk("arst_oob", 32'(bus.oob_err_o), 32'h0);
    chk("arst_cnt", 32'(bus.fetch_cnt_o), 32'h0);
    bus.stall_i = 0; #1;
    rst = 0;
    tick; chk_ifid("arst_first", 32'h4, 32'h1000_0000, 1'b1);

    // Randomized traffic
    for (int i = 0; i < int'(IMEM_WORDS); i++) mem[i] = $urandom;
    for (int n = 0; n < 3000; n++) begin
      bus.stall_i    = ($urandom_range(0, 3) == 0);
      bus.flush_i    = ($urandom_range(0, 7) == 0);
      bus.redirect_i = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 15))
        0:       bus.redirect_pc_i = $urandom;
        1:       bus.redirect_pc_i = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: bus.redirect_pc_i = 32'($urandom_range(0, 36 * 4 + 3));
      endcase
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1;
        #1 rst = 0;
      end
      tick;
    end

    // Counter saturation
    bus.stall_i = 0; bus.flush_i = 0; bus.redirect_i = 0;
    #2 rst = 1;
    #1 rst = 0;
    repeat (20) tick;
    chk("sat_cnt", 32'(bus.fetch_cnt_o), 32'hF);

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
